// File: rtl/r22sdf_reorder_if.sv
// Sample stream and handshake bundle of the R22SDF output reorder buffer.
// The buffer is the slave; the upstream pipeline plus the sink are the master side.
interface r22sdf_reorder_if #(
    parameter int data_resolution = 16,
    parameter int addr_width      = 8
);
    logic                       din_vld;
    logic                       din_sof;
    logic [data_resolution-1:0] din_r;
    logic [data_resolution-1:0] din_i;
    logic                       dout_rdy;
    logic                       dout_vld;
    logic                       dout_sof;
    logic                       dout_eof;
    logic [addr_width-1:0]      dout_idx;
    logic [data_resolution-1:0] dout_r;
    logic [data_resolution-1:0] dout_i;
    logic                       ovf_err;
    logic                       sof_err;

    modport master (
        output din_vld, din_sof, din_r, din_i, dout_rdy,
        input  dout_vld, dout_sof, dout_eof, dout_idx, dout_r, dout_i, ovf_err, sof_err
    );

    modport slave (
        input  din_vld, din_sof, din_r, din_i, dout_rdy,
        output dout_vld, dout_sof, dout_eof, dout_idx, dout_r, dout_i, ovf_err, sof_err
    );
endinterface

// File: rtl/r22sdf_reorder.sv
// Ping-pong reorder buffer behind the R22SDF FFT: stores a bit-reversed frame
// and replays it in natural bin order over a registered ready/valid output.
module r22sdf_reorder #(
    parameter int data_resolution = 16,
    parameter int fft_length      = 256,
    parameter int bitrev_en       = 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            sys_en,
    r22sdf_reorder_if.slave bus
);
    localparam int AW = $clog2(fft_length);
    localparam int MW = 2 * data_resolution;
    localparam bit USE_BITREV = (bitrev_en != 0);
    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_t;
    typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_RUN  = 1'b1} rd_state_t;

    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] v);
        logic [AW-1:0] res;
        for (int b = 0; b < AW; b++) begin
            res[b] = v[AW-1-b];
        end
        return res;
    endfunction

    logic [MW-1:0] mem_r [0:2*fft_length-1];

    wr_state_t     wr_state_r, wr_state_nxt_s;
    logic [AW-1:0] wr_cnt_r, wr_cnt_nxt_s;
    logic          wr_bank_r, wr_bank_nxt_s;
    logic [1:0]    full_r;
    logic [1:0]    full_set_s;
    logic [1:0]    full_clr_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] wr_addr_s;
    logic          bank_free_s;
    logic          ovf_s;
    logic          sof_err_s;

    rd_state_t     rd_state_r, rd_state_nxt_s;
    logic [AW-1:0] rd_cnt_r, rd_cnt_nxt_s;
    logic          rd_bank_r, rd_bank_nxt_s;
    logic          drn_bank_r;
    logic          iss_s;
    logic [AW-1:0] iss_idx_s;
    logic [MW-1:0] rd_word_s;
    logic          pop_s;
    logic          eof_pop_s;
    logic          can_issue_s;

    logic          dout_vld_r, dout_sof_r, dout_eof_r;
    logic [AW-1:0] dout_idx_r;
    logic [MW-1:0] dout_data_r;
    logic          skid_vld_r;
    logic [AW-1:0] skid_idx_r;
    logic [MW-1:0] skid_data_r;
    logic          ovf_err_r, sof_err_r;

    assign pop_s     = dout_vld_r & bus.dout_rdy;
    assign eof_pop_s = pop_s & dout_eof_r;
    assign full_clr_s = eof_pop_s ? (drn_bank_r ? 2'b10 : 2'b01) : 2'b00;
    // A bank whose last sample leaves this cycle has already been fully read, so it may be refilled now.
    assign bank_free_s = !full_r[wr_bank_r] || full_clr_s[wr_bank_r];
    // Output register plus skid hold at most two samples; issue only if one slot is free after this cycle.
    assign can_issue_s = !skid_vld_r || pop_s;
    assign wr_addr_s = USE_BITREV ? bit_reverse(wr_idx_s) : wr_idx_s;
    assign rd_word_s = mem_r[{rd_bank_r, iss_idx_s}];

    // Write FSM next state, bank fill bookkeeping and error detection
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        wr_cnt_nxt_s   = wr_cnt_r;
        wr_bank_nxt_s  = wr_bank_r;
        wr_en_s        = 1'b0;
        wr_idx_s       = wr_cnt_r;
        full_set_s     = 2'b00;
        ovf_s          = 1'b0;
        sof_err_s      = 1'b0;
        case (wr_state_r)
            WR_IDLE: begin
                if (bus.din_vld && bus.din_sof) begin
                    if (bank_free_s) begin
                        wr_en_s        = 1'b1;
                        wr_idx_s       = IDX_ZERO;
                        wr_cnt_nxt_s   = IDX_ONE;
                        wr_state_nxt_s = WR_FILL;
                    end else begin
                        ovf_s = 1'b1;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            WR_FILL: begin
                if (bus.din_vld && bus.din_sof) begin
                    sof_err_s    = 1'b1;
                    wr_en_s      = 1'b1;
                    wr_idx_s     = IDX_ZERO;
                    wr_cnt_nxt_s = IDX_ONE;
                end else if (bus.din_vld) begin
                    wr_en_s = 1'b1;
                    if (wr_cnt_r == IDX_LAST) begin
                        full_set_s[wr_bank_r] = 1'b1;
                        wr_bank_nxt_s  = ~wr_bank_r;
                        wr_cnt_nxt_s   = IDX_ZERO;
                        wr_state_nxt_s = WR_IDLE;
                    end else begin
                        wr_cnt_nxt_s = wr_cnt_r + IDX_ONE;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: wr_state_nxt_s = WR_IDLE;
        endcase
    end

    // Read FSM next state: issue natural-order addresses, chaining straight into a full next bank
    always_comb begin
        rd_state_nxt_s = rd_state_r;
        rd_cnt_nxt_s   = rd_cnt_r;
        rd_bank_nxt_s  = rd_bank_r;
        iss_s          = 1'b0;
        iss_idx_s      = rd_cnt_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (full_r[rd_bank_r] && can_issue_s) begin
                    iss_s          = 1'b1;
                    iss_idx_s      = IDX_ZERO;
                    rd_cnt_nxt_s   = IDX_ONE;
                    rd_state_nxt_s = RD_RUN;
                end else begin
                    iss_s = 1'b0;
                end
            end
            RD_RUN: begin
                if (can_issue_s) begin
                    iss_s = 1'b1;
                    if (rd_cnt_r == IDX_LAST) begin
                        rd_bank_nxt_s  = ~rd_bank_r;
                        rd_cnt_nxt_s   = IDX_ZERO;
                        rd_state_nxt_s = full_r[~rd_bank_r] ? RD_RUN : RD_IDLE;
                    end else begin
                        rd_cnt_nxt_s = rd_cnt_r + IDX_ONE;
                    end
                end else begin
                    iss_s = 1'b0;
                end
            end
            default: rd_state_nxt_s = RD_IDLE;
        endcase
    end

    // Sample storage, two banks addressed as {bank, index}
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && sys_en && wr_en_s) begin
            mem_r[{wr_bank_r, wr_addr_s}] <= {bus.din_r, bus.din_i};
        end
    end

    // Write-side state, bank pointer and full flags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_state_r <= WR_IDLE;
            wr_cnt_r   <= IDX_ZERO;
            wr_bank_r  <= 1'b0;
            full_r     <= 2'b00;
        end else if (sys_en) begin
            wr_state_r <= wr_state_nxt_s;
            wr_cnt_r   <= wr_cnt_nxt_s;
            wr_bank_r  <= wr_bank_nxt_s;
            full_r     <= (full_r | full_set_s) & ~full_clr_s;
        end
    end

    // Read-side state, issue pointer and draining-bank pointer
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_state_r <= RD_IDLE;
            rd_cnt_r   <= IDX_ZERO;
            rd_bank_r  <= 1'b0;
            drn_bank_r <= 1'b0;
        end else if (sys_en) begin
            rd_state_r <= rd_state_nxt_s;
            rd_cnt_r   <= rd_cnt_nxt_s;
            rd_bank_r  <= rd_bank_nxt_s;
            if (eof_pop_s) begin
                drn_bank_r <= ~drn_bank_r;
            end
        end
    end

    // Output register with skid: the head only moves when empty or transferring
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dout_vld_r  <= 1'b0;
            dout_sof_r  <= 1'b0;
            dout_eof_r  <= 1'b0;
            dout_idx_r  <= IDX_ZERO;
            dout_data_r <= {MW{1'b0}};
            skid_vld_r  <= 1'b0;
            skid_idx_r  <= IDX_ZERO;
            skid_data_r <= {MW{1'b0}};
        end else if (sys_en) begin
            if (!dout_vld_r || pop_s) begin
                if (skid_vld_r) begin
                    dout_vld_r  <= 1'b1;
                    dout_sof_r  <= (skid_idx_r == IDX_ZERO);
                    dout_eof_r  <= (skid_idx_r == IDX_LAST);
                    dout_idx_r  <= skid_idx_r;
                    dout_data_r <= skid_data_r;
                    skid_vld_r  <= iss_s;
                    if (iss_s) begin
                        skid_idx_r  <= iss_idx_s;
                        skid_data_r <= rd_word_s;
                    end
                end else if (iss_s) begin
                    dout_vld_r  <= 1'b1;
                    dout_sof_r  <= (iss_idx_s == IDX_ZERO);
                    dout_eof_r  <= (iss_idx_s == IDX_LAST);
                    dout_idx_r  <= iss_idx_s;
                    dout_data_r <= rd_word_s;
                end else begin
                    dout_vld_r <= 1'b0;
                    dout_sof_r <= 1'b0;
                    dout_eof_r <= 1'b0;
                end
            end else if (iss_s) begin
                skid_vld_r  <= 1'b1;
                skid_idx_r  <= iss_idx_s;
                skid_data_r <= rd_word_s;
            end
        end
    end

    // One-cycle error pulses, suppressed while the block is disabled
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ovf_err_r <= 1'b0;
            sof_err_r <= 1'b0;
        end else if (sys_en) begin
            ovf_err_r <= ovf_s;
            sof_err_r <= sof_err_s;
        end else begin
            ovf_err_r <= 1'b0;
            sof_err_r <= 1'b0;
        end
    end

    assign bus.dout_vld = dout_vld_r;
    assign bus.dout_sof = dout_sof_r;
    assign bus.dout_eof = dout_eof_r;
    assign bus.dout_idx = dout_idx_r;
    assign bus.dout_r   = dout_data_r[MW-1:data_resolution];
    assign bus.dout_i   = dout_data_r[data_resolution-1:0];
    assign bus.ovf_err  = ovf_err_r;
    assign bus.sof_err  = sof_err_r;
endmodule

// File: tb/tb_r22sdf_reorder.sv
// Directed bench for r22sdf_reorder at N=16 with bit-reversed input; every
// accepted output sample is queued and compared with hand-derived values.
module tb_r22sdf_reorder;
    localparam int DW = 16;
    localparam int N  = 16;
    localparam int AW = 4;

    logic clk     = 1'b0;
    logic sys_rst = 1'b1;
    logic sys_en  = 1'b1;
    always #5 clk = ~clk;

    r22sdf_reorder_if #(.data_resolution(DW), .addr_width(AW)) bus ();

    r22sdf_reorder #(.data_resolution(DW), .fft_length(N), .bitrev_en(1)) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .sys_en  (sys_en),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    // Natural bin k holds the sample that arrived at position bitrev4(k)
    int exp_ord [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [37:0] q[$];
    logic [37:0] snap_now;
    logic [37:0] prev_snap;
    bit mon_en    = 1'b0;
    bit rnd_rdy   = 1'b0;
    bit hold_prev = 1'b0;
    int ovf_cnt = 0;
    int sof_cnt = 0;
    int run_cnt = 0;
    int max_run = 0;

    assign snap_now = {bus.dout_sof, bus.dout_eof, bus.dout_idx, bus.dout_r, bus.dout_i};

    function automatic logic [37:0] exp_entry(input logic [7:0] tag, input int k);
        logic [15:0] v;
        v = {tag, 4'h0, 4'(exp_ord[k])};
        return {(k == 0), (k == 15), 4'(k), v, ~v};
    endfunction

    // Transfer capture, stall stability and pulse counting, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en && !sys_rst) begin
            if (hold_prev) begin
                total++;
                if ({bus.dout_vld, snap_now} !== {1'b1, prev_snap}) begin
                    bad++;
                    $display("FAIL stall_hold: got vld=%b %h want vld=1 %h", bus.dout_vld, snap_now, prev_snap);
                end
            end
            if (bus.dout_vld && bus.dout_rdy && sys_en) q.push_back(snap_now);
            hold_prev = bus.dout_vld && !(bus.dout_rdy && sys_en);
            prev_snap = snap_now;
            if (bus.ovf_err) ovf_cnt++;
            if (bus.sof_err) sof_cnt++;
            run_cnt = bus.dout_vld ? run_cnt + 1 : 0;
            if (run_cnt > max_run) max_run = run_cnt;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.dout_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_q(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (q.size() >= n) break;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] tag, output logic ovf_at, output logic sof_err_at);
        ovf_at = 1'b0;
        sof_err_at = 1'b0;
        for (int j = 0; j < 16; j++) begin
            bus.din_vld = 1'b1;
            bus.din_sof = (j == 0);
            bus.din_r   = {tag, 4'h0, 4'(j)};
            bus.din_i   = ~{tag, 4'h0, 4'(j)};
            tick();
            if (j == 0) begin
                ovf_at     = bus.ovf_err;
                sof_err_at = bus.sof_err;
            end
        end
        bus.din_vld = 1'b0;
        bus.din_sof = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        sys_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.din_vld  = 1'($urandom_range(0, 1));
            bus.din_sof  = 1'($urandom_range(0, 1));
            bus.din_r    = 16'($urandom);
            bus.din_i    = 16'($urandom);
            bus.dout_rdy = 1'($urandom_range(0, 1));
            tick();
            outs = {bus.dout_vld, bus.dout_sof, bus.dout_eof, bus.dout_idx, bus.dout_r,
                    bus.dout_i, bus.ovf_err, bus.sof_err};
            total++;
            if (outs !== 40'h0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", c, outs);
            end
        end
        bus.din_vld  = 1'b0;
        bus.din_sof  = 1'b0;
        bus.dout_rdy = 1'b1;
        sys_rst = 1'b0;
        mon_en  = 1'b1;
        tick();
    endtask

    task automatic test_order();
        logic o, s;
        q.delete();
        bus.dout_rdy = 1'b1;
        send_frame(8'h00, o, s);
        total++;
        if (bus.dout_vld !== 1'b0) begin
            bad++;
            $display("FAIL order_latency_early: got vld=%b want 0", bus.dout_vld);
        end
        tick();
        total++;
        if ({bus.dout_vld, bus.dout_sof, bus.dout_idx} !== {1'b1, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL order_latency_first: got vld/sof/idx=%b/%b/%0d want 1/1/0",
                     bus.dout_vld, bus.dout_sof, bus.dout_idx);
        end
        wait_q(16, 40);
        total++;
        if (q.size() != 16) begin
            bad++;
            $display("FAIL order_count: got %0d want 16", q.size());
        end
        for (int k = 0; k < 16 && k < q.size(); k++) begin
            total++;
            if (q[k] !== exp_entry(8'h00, k)) begin
                bad++;
                $display("FAIL order[%0d]: got %h want %h", k, q[k], exp_entry(8'h00, k));
            end
        end
        total++;
        if ({bus.dout_vld, bus.dout_r} !== {1'b0, 16'h000f}) begin
            bad++;
            $display("FAIL order_idle_hold: got vld=%b r=%h want vld=0 r=000f", bus.dout_vld, bus.dout_r);
        end
    endtask

    task automatic test_continuous();
        logic o, s;
        int ovf0;
        q.delete();
        max_run = 0;
        ovf0 = ovf_cnt;
        bus.dout_rdy = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(8'(8'h10 + f), o, s);
        wait_q(48, 60);
        total++;
        if (q.size() != 48) begin
            bad++;
            $display("FAIL cont_count: got %0d want 48", q.size());
        end
        for (int n = 0; n < 48 && n < q.size(); n++) begin
            total++;
            if (q[n] !== exp_entry(8'(8'h10 + n / 16), n % 16)) begin
                bad++;
                $display("FAIL cont[%0d]: got %h want %h", n, q[n], exp_entry(8'(8'h10 + n / 16), n % 16));
            end
        end
        total++;
        if (max_run != 48) begin
            bad++;
            $display("FAIL cont_contiguous: got run %0d want 48", max_run);
        end
        total++;
        if (ovf_cnt != ovf0) begin
            bad++;
            $display("FAIL cont_no_ovf: got %0d pulses want 0", ovf_cnt - ovf0);
        end
    endtask

    task automatic test_overflow();
        logic oa, ob, oc, s;
        q.delete();
        ovf_cnt = 0;
        bus.dout_rdy = 1'b0;
        send_frame(8'h31, oa, s);
        send_frame(8'h32, ob, s);
        send_frame(8'h33, oc, s);
        for (int c = 0; c < 5; c++) tick();
        total++;
        if ({oa, ob, oc} !== 3'b001) begin
            bad++;
            $display("FAIL ovf_at_sof: got A/B/C=%b want 001", {oa, ob, oc});
        end
        total++;
        if (ovf_cnt != 1) begin
            bad++;
            $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL ovf_stalled_out: got %0d transfers want 0", q.size());
        end
        bus.dout_rdy = 1'b1;
        wait_q(32, 80);
        for (int c = 0; c < 20; c++) tick();
        total++;
        if (q.size() != 32) begin
            bad++;
            $display("FAIL ovf_count_ab: got %0d want 32", q.size());
        end
        for (int n = 0; n < 32 && n < q.size(); n++) begin
            total++;
            if (q[n] !== exp_entry(8'(8'h31 + n / 16), n % 16)) begin
                bad++;
                $display("FAIL ovf_ab[%0d]: got %h want %h", n, q[n], exp_entry(8'(8'h31 + n / 16), n % 16));
            end
        end
        send_frame(8'h34, oa, s);
        wait_q(48, 40);
        total++;
        if (q.size() != 48) begin
            bad++;
            $display("FAIL ovf_count_d: got %0d want 48", q.size());
        end
        for (int n = 32; n < 48 && n < q.size(); n++) begin
            total++;
            if (q[n] !== exp_entry(8'h34, n - 32)) begin
                bad++;
                $display("FAIL ovf_d[%0d]: got %h want %h", n - 32, q[n], exp_entry(8'h34, n - 32));
            end
        end
    endtask

    task automatic test_random_rdy();
        logic o, s;
        q.delete();
        ovf_cnt = 0;
        rnd_rdy = 1'b1;
        for (int f = 0; f < 10; f++) begin
            send_frame(8'(8'h20 + f), o, s);
            wait_q(16 * (f + 1), 400);
        end
        rnd_rdy = 1'b0;
        bus.dout_rdy = 1'b1;
        total++;
        if (q.size() != 160) begin
            bad++;
            $display("FAIL rand_count: got %0d want 160", q.size());
        end
        for (int n = 0; n < 160 && n < q.size(); n++) begin
            total++;
            if (q[n] !== exp_entry(8'(8'h20 + n / 16), n % 16)) begin
                bad++;
                $display("FAIL rand[%0d]: got %h want %h", n, q[n], exp_entry(8'(8'h20 + n / 16), n % 16));
            end
        end
        total++;
        if (ovf_cnt != 0) begin
            bad++;
            $display("FAIL rand_no_ovf: got %0d pulses want 0", ovf_cnt);
        end
    endtask

    task automatic test_mid_sof();
        logic o, s;
        q.delete();
        sof_cnt = 0;
        bus.dout_rdy = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus.din_vld = 1'b1;
            bus.din_sof = (j == 0);
            bus.din_r   = {8'h50, 4'h0, 4'(j)};
            bus.din_i   = ~{8'h50, 4'h0, 4'(j)};
            tick();
        end
        send_frame(8'h60, o, s);
        total++;
        if (s !== 1'b1) begin
            bad++;
            $display("FAIL sof_err_pulse: got %b want 1", s);
        end
        wait_q(16, 40);
        for (int c = 0; c < 20; c++) tick();
        total++;
        if (sof_cnt != 1) begin
            bad++;
            $display("FAIL sof_err_count: got %0d want 1", sof_cnt);
        end
        total++;
        if (q.size() != 16) begin
            bad++;
            $display("FAIL sof_count: got %0d want 16", q.size());
        end
        for (int k = 0; k < 16 && k < q.size(); k++) begin
            total++;
            if (q[k] !== exp_entry(8'h60, k)) begin
                bad++;
                $display("FAIL sof_frame[%0d]: got %h want %h", k, q[k], exp_entry(8'h60, k));
            end
        end
    endtask

    task automatic test_enable();
        logic o, s;
        logic [3:0]  cap_idx;
        logic [15:0] cap_r;
        q.delete();
        bus.dout_rdy = 1'b1;
        send_frame(8'h70, o, s);
        for (int c = 0; c < 40; c++) begin
            if (bus.dout_vld && bus.dout_idx == 4'd5) break;
            tick();
        end
        total++;
        if ({bus.dout_vld, bus.dout_idx} !== {1'b1, 4'd5}) begin
            bad++;
            $display("FAIL en_reach_idx5: got vld/idx=%b/%0d want 1/5", bus.dout_vld, bus.dout_idx);
        end
        cap_idx = bus.dout_idx;
        cap_r   = bus.dout_r;
        sys_en  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({bus.dout_vld, bus.dout_idx, bus.dout_r} !== {1'b1, cap_idx, cap_r}) begin
                bad++;
                $display("FAIL en_frozen[%0d]: got idx=%0d r=%h want idx=%0d r=%h",
                         c, bus.dout_idx, bus.dout_r, cap_idx, cap_r);
            end
        end
        sys_en = 1'b1;
        wait_q(16, 40);
        total++;
        if (q.size() != 16) begin
            bad++;
            $display("FAIL en_count: got %0d want 16", q.size());
        end
        for (int k = 0; k < 16 && k < q.size(); k++) begin
            total++;
            if (q[k] !== exp_entry(8'h70, k)) begin
                bad++;
                $display("FAIL en_frame[%0d]: got %h want %h", k, q[k], exp_entry(8'h70, k));
            end
        end
    endtask

    initial begin
        bus.din_vld  = 1'b0;
        bus.din_sof  = 1'b0;
        bus.din_r    = 16'h0;
        bus.din_i    = 16'h0;
        bus.dout_rdy = 1'b0;
        test_reset();
        test_order();
        test_continuous();
        test_overflow();
        test_random_rdy();
        test_mid_sof();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
